dmem_ctrl: RTL and testbench

Data-memory access controller: the initiator side of the 64-word data memory port (mem_addr/mem_din/mem_wea/mem_dout). It accepts load, store and block-copy requests from the processor datapath over a valid/ready handshake. It sequences glitch-safe accesses against the level-sensitive memory and returns one response pulse per request. It sits between the execute stage and the data memory.

---
 rtl/dmem_ctrl_pkg.sv | 23 ++
 rtl/dmem_ctrl_if.sv | 33 +++
 rtl/dmem_range_chk.sv | 37 +++
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: opcodes, FSM states
// and the default implemented memory depth.
package dmem_ctrl_pkg;

    localparam int DEPTH_DEF = 64;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake plus the level-sensitive memory port.
// master = datapath + memory side, slave = the controller.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_src;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wea;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output req_valid, req_op, req_addr, req_src, req_len, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_wea
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_len, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_din, mem_wea
    );

endinterface

// File: rtl/dmem_range_chk.sv
// Combinational request validation: address range, copy extents and opcode.
module dmem_range_chk
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 7,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  op_e               op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              err_o
);
    localparam int AW1 = ADDR_W + 1;

    // One extra bit so base+len can never wrap back into range.
    logic [AW1-1:0] depth_x;
    logic [AW1-1:0] addr_x;
    logic [AW1-1:0] src_end;
    logic [AW1-1:0] dst_end;

    assign depth_x = AW1'(DEPTH);
    assign addr_x  = {1'b0, addr_i};
    assign src_end = {1'b0, src_i} + AW1'(len_i);
    assign dst_end = {1'b0, addr_i} + AW1'(len_i);

    always_comb begin
        err_o = 1'b0;
        case (op_i)
            OP_LOAD, OP_STORE: err_o = (addr_x >= depth_x);
            OP_COPY:           err_o = (len_i != '0) && ((src_end > depth_x) || (dst_end > depth_x));
            default:           err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: sequences glitch-safe loads, stores and
// ascending block copies against a level-sensitive memory.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LEN_W  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);
    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              mem_wea_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    op_e               req_op_d;
    logic              range_err_d;
    logic [LEN_W-1:0]  idx_d;
    logic              last_word_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] next_rd_addr_d;

    assign req_op_d       = op_e'(bus.req_op);
    assign idx_d          = idx_q + 1'b1;
    assign last_word_d    = (idx_d == len_q);
    assign wr_addr_d      = dst_q + ADDR_W'(idx_q);
    assign next_rd_addr_d = src_q + ADDR_W'(idx_d);

    dmem_range_chk #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH)
    ) u_range_chk (
        .op_i   (req_op_d),
        .addr_i (bus.req_addr),
        .src_i  (bus.req_src),
        .len_i  (bus.req_len),
        .err_o  (range_err_d)
    );

    // Address/data only move on transitions into RD or WR_SETUP, or out of
    // HOLD, so they are always stable around the one-cycle write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            dst_q       <= '0;
            src_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wea_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= req_op_d;
                        dst_q <= bus.req_addr;
                        src_q <= bus.req_src;
                        len_q <= bus.req_len;
                        idx_q <= '0;
                        if (range_err_d || (req_op_d == OP_COPY && bus.req_len == '0)) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= range_err_d;
                            rsp_rdata_q <= '0;
                        end else if (req_op_d == OP_LOAD) begin
                            state_q    <= ST_RD;
                            mem_addr_q <= bus.req_addr;
                        end else if (req_op_d == OP_STORE) begin
                            state_q    <= ST_WR_SETUP;
                            mem_addr_q <= bus.req_addr;
                            mem_din_q  <= bus.req_wdata;
                        end else begin
                            state_q    <= ST_RD;
                            mem_addr_q <= bus.req_src;
                        end
                    end
                end
                ST_RD: begin
                    if (op_q == OP_LOAD) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= bus.mem_dout;
                    end else begin
                        state_q    <= ST_WR_SETUP;
                        mem_din_q  <= bus.mem_dout;
                        mem_addr_q <= wr_addr_d;
                    end
                end
                ST_WR_SETUP: begin
                    state_q   <= ST_WR_STROBE;
                    mem_wea_q <= 1'b1;
                end
                ST_WR_STROBE: begin
                    state_q   <= ST_WR_HOLD;
                    mem_wea_q <= 1'b0;
                end
                ST_WR_HOLD: begin
                    if (op_q == OP_COPY && !last_word_d) begin
                        state_q    <= ST_RD;
                        mem_addr_q <= next_rd_addr_d;
                        idx_q      <= idx_d;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_wea   = mem_wea_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a 64-word level-sensitive memory model.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(7)) bus ();

    dmem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH(64), .LEN_W(7)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [15:0] mem [64] = '{default: 16'h0000};
    always @(posedge clk) if (bus.mem_wea && bus.mem_addr < 16'd64) mem[bus.mem_addr[5:0]] <= bus.mem_din;
    assign bus.mem_dout = (bus.mem_addr < 16'd64) ? mem[bus.mem_addr[5:0]] : 16'h0000;

    int checks = 0;
    int failures = 0;

    int          acc_k;
    int          rsp_cyc;
    logic [15:0] rsp_rd;
    logic        rsp_e;
    int          wea_cnt;
    logic [15:0] wea_addr [8];
    int          wea_cyc [8];
    logic [15:0] tr_addr [32];
    logic [15:0] tr_din [32];
    logic        tr_wea [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns sampled just after the accept edge, i.e. observing cycle 1.
    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] src,
                         input logic [6:0] len, input logic [15:0] wd);
        logic rdy;
        bit   acc;
        bus.req_op = op; bus.req_addr = addr; bus.req_src = src;
        bus.req_len = len; bus.req_wdata = wd; bus.req_valid = 1'b1;
        acc = 0; acc_k = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            rdy = bus.req_ready;
            tick();
            acc_k++;
            if (rdy) acc = 1;
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic collect();
        rsp_cyc = -1; rsp_rd = 'x; rsp_e = 1'bx; wea_cnt = 0;
        for (int c = 1; c < 300; c++) begin
            if (c < 32) begin
                tr_addr[c] = bus.mem_addr; tr_din[c] = bus.mem_din; tr_wea[c] = bus.mem_wea;
            end
            if (bus.mem_wea) begin
                if (wea_cnt < 8) begin
                    wea_addr[wea_cnt] = bus.mem_addr;
                    wea_cyc[wea_cnt]  = c;
                end
                wea_cnt++;
            end
            if (bus.rsp_valid) begin
                rsp_cyc = c; rsp_rd = bus.rsp_rdata; rsp_e = bus.rsp_err;
                break;
            end
            tick();
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] src,
                          input logic [6:0] len, input logic [15:0] wd);
        issue(op, addr, src, len, wd);
        collect();
    endtask

    initial begin
        logic [15:0] pre [4];
        int rsp_seen;
        pre[0] = 16'h1111; pre[1] = 16'h2222; pre[2] = 16'h3333; pre[3] = 16'h4444;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0;
        bus.req_src = '0; bus.req_len = '0; bus.req_wdata = '0;
        repeat (3) tick();

        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_wea", bus.mem_wea, 0);
        rst_n = 1'b1;
        tick();

        // STORE 0xBEEF @5
        do_req(2'b01, 16'd5, 16'd0, 7'd0, 16'hBEEF);
        chk("st_rsp_cyc", rsp_cyc, 4);
        chk("st_err", rsp_e, 0);
        chk("st_rdata", rsp_rd, 0);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("st_addr_c%0d", c), tr_addr[c], 16'd5);
            chk($sformatf("st_din_c%0d", c), tr_din[c], 16'hBEEF);
        end
        chk("st_wea_c1", tr_wea[1], 0);
        chk("st_wea_c2", tr_wea[2], 1);
        chk("st_wea_c3", tr_wea[3], 0);
        chk("st_wea_cnt", wea_cnt, 1);
        chk("st_mem5", mem[5], 16'hBEEF);

        // LOAD @5, issued straight after the store response
        do_req(2'b00, 16'd5, 16'd0, 7'd0, 16'h0);
        chk("ld_accept_wait", acc_k, 2);
        chk("ld_rsp_cyc", rsp_cyc, 2);
        chk("ld_rdata", rsp_rd, 16'hBEEF);
        chk("ld_err", rsp_e, 0);
        chk("ld_wea_cnt", wea_cnt, 0);

        // Error paths
        do_req(2'b01, 16'd64, 16'd0, 7'd0, 16'h1234);
        chk("st64_rsp_cyc", rsp_cyc, 1);
        chk("st64_err", rsp_e, 1);
        chk("st64_rdata", rsp_rd, 0);
        chk("st64_wea_cnt", wea_cnt, 0);
        do_req(2'b11, 16'd3, 16'd0, 7'd0, 16'h0);
        chk("op11_rsp_cyc", rsp_cyc, 1);
        chk("op11_err", rsp_e, 1);
        chk("op11_wea_cnt", wea_cnt, 0);
        do_req(2'b00, 16'hFFFF, 16'd0, 7'd0, 16'h0);
        chk("ldffff_err", rsp_e, 1);

        // Preload and COPY 0..3 -> 32..35
        for (int i = 0; i < 4; i++) do_req(2'b01, 16'(i), 16'd0, 7'd0, pre[i]);
        do_req(2'b10, 16'd32, 16'd0, 7'd4, 16'h0);
        chk("cp_rsp_cyc", rsp_cyc, 17);
        chk("cp_err", rsp_e, 0);
        chk("cp_rdata", rsp_rd, 0);
        chk("cp_wea_cnt", wea_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cp_wea_addr%0d", i), wea_addr[i], 16'(32 + i));
            chk($sformatf("cp_wea_cyc%0d", i), wea_cyc[i], 4 * i + 3);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(2'b00, 16'(32 + i), 16'd0, 7'd0, 16'h0);
            chk($sformatf("cp_ld%0d", 32 + i), rsp_rd, pre[i]);
        end

        // COPY len=0 and out-of-range copy: no memory access
        do_req(2'b10, 16'd10, 16'd0, 7'd0, 16'h0);
        chk("cp0_rsp_cyc", rsp_cyc, 1);
        chk("cp0_err", rsp_e, 0);
        chk("cp0_wea_cnt", wea_cnt, 0);
        chk("cp0_addr_held", tr_addr[1], 16'd35);
        do_req(2'b10, 16'd0, 16'd60, 7'd5, 16'h0);
        chk("cp60_rsp_cyc", rsp_cyc, 1);
        chk("cp60_err", rsp_e, 1);
        chk("cp60_wea_cnt", wea_cnt, 0);
        do_req(2'b10, 16'd60, 16'd0, 7'd4, 16'h0);
        chk("cp_dst60_err", rsp_e, 0);
        chk("cp_dst60_rsp_cyc", rsp_cyc, 17);

        // Reset during WR_SETUP of the second copy word
        issue(2'b10, 16'd40, 16'd0, 7'd4, 16'h0);
        repeat (5) tick();
        chk("mid_addr_setup", bus.mem_addr, 16'd41);
        chk("mid_wea_setup", bus.mem_wea, 0);
        rst_n = 1'b0;
        tick();
        chk("mid_wea_after_rst", bus.mem_wea, 0);
        chk("mid_rsp_after_rst", bus.rsp_valid, 0);
        chk("mid_ready_in_rst", bus.req_ready, 1);
        chk("mid_addr_rst", bus.mem_addr, 0);
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.rsp_valid || bus.mem_wea) rsp_seen++;
        end
        chk("mid_quiet_after_rst", rsp_seen, 0);
        chk("mid_ready_after_rst", bus.req_ready, 1);
        chk("mid_mem40", mem[40], 16'h1111);
        chk("mid_mem41", mem[41], 16'h0000);
        do_req(2'b00, 16'd40, 16'd0, 7'd0, 16'h0);
        chk("post_rst_ld_cyc", rsp_cyc, 2);
        chk("post_rst_ld", rsp_rd, 16'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
